// File: rtl/rf_dbg_pkg.sv
// rf_dbg_pkg: shared constants and state type for the register-file debug sequencer
package rf_dbg_pkg;
    localparam int REG_NUM_C = 32;
    localparam int ADDR_W_C  = $clog2(REG_NUM_C);
    typedef enum logic [1:0] {IDLE, CLEAR, DUMP, DRAIN} rf_dbg_state_t;
endpackage

// File: rtl/rf_dbg_out_reg.sv
// rf_dbg_out_reg: single-entry valid/ready holding register for {addr, data} dump beats
module rf_dbg_out_reg #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          ready,
    input  logic [AW-1:0] load_addr,
    input  logic [DW-1:0] load_data,
    output logic          accept,
    output logic          valid,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data
);
    assign accept = push && (!valid || ready);
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            valid <= 1'b0;
            addr  <= '0;
            data  <= '0;
        end else if (accept) begin
            valid <= 1'b1;
            addr  <= load_addr;
            data  <= load_data;
        end else if (ready) begin
            valid <= 1'b0;
        end
endmodule

// File: rtl/rf_debug_port.sv
// rf_debug_port: clear/dump sequencer owning the register file's write port and read port 1
module rf_debug_port
    import rf_dbg_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_NUM = REG_NUM_C,
    localparam int AW     = $clog2(REG_NUM)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_start_i,
    input  logic              dump_start_i,
    output logic              busy_o,
    output logic              done_o,
    input  logic              core_we_i,
    input  logic [AW-1:0]     core_waddr_i,
    input  logic [DATA_W-1:0] core_wdata_i,
    input  logic [AW-1:0]     core_raddr1_i,
    output logic              rf_we_o,
    output logic [AW-1:0]     rf_waddr_o,
    output logic [DATA_W-1:0] rf_wdata_o,
    output logic [AW-1:0]     rf_raddr1_o,
    input  logic [DATA_W-1:0] rf_rdata1_i,
    output logic              dump_valid_o,
    input  logic              dump_ready_i,
    output logic [AW-1:0]     dump_addr_o,
    output logic [DATA_W-1:0] dump_data_o
);
    localparam logic [AW-1:0] LAST = AW'(REG_NUM - 1);
    rf_dbg_state_t state, state_n;
    logic [AW-1:0] idx, idx_n;
    logic          done_n, accept;
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            state  <= IDLE;
            idx    <= '0;
            done_o <= 1'b0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            done_o <= done_n;
        end
    // the terminal compare stops idx before it can wrap
    always_comb begin
        state_n = state;
        idx_n   = idx;
        done_n  = 1'b0;
        case (state)
            IDLE:
                if (clear_start_i) begin
                    state_n = CLEAR;
                    idx_n   = AW'(1);
                end else if (dump_start_i) begin
                    state_n = DUMP;
                    idx_n   = '0;
                end
            CLEAR: begin
                idx_n = idx + AW'(1);
                if (idx == LAST) begin
                    state_n = IDLE;
                    idx_n   = '0;
                    done_n  = 1'b1;
                end
            end
            DUMP:
                if (accept) begin
                    idx_n = idx + AW'(1);
                    if (idx == LAST) begin
                        state_n = DRAIN;
                        idx_n   = '0;
                    end
                end
            DRAIN:
                if (dump_valid_o && dump_ready_i) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            default: state_n = IDLE;
        endcase
    end
    always_comb begin
        busy_o      = state != IDLE;
        rf_we_o     = busy_o ? state == CLEAR : core_we_i;
        rf_waddr_o  = busy_o ? idx : core_waddr_i;
        rf_wdata_o  = busy_o ? '0 : core_wdata_i;
        rf_raddr1_o = busy_o ? idx : core_raddr1_i;
    end
    rf_dbg_out_reg #(.AW(AW), .DW(DATA_W)) u_out (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (state == DUMP),
        .ready     (dump_ready_i),
        .load_addr (idx),
        .load_data (rf_rdata1_i),
        .accept    (accept),
        .valid     (dump_valid_o),
        .addr      (dump_addr_o),
        .data      (dump_data_o)
    );
endmodule

// File: tb/tb_rf_debug_port.sv
// tb_rf_debug_port: directed bench with a register-file model and a write/beat scoreboard
module tb_rf_debug_port;
    import rf_dbg_pkg::*;
    localparam int DW = 32;
    localparam int AW = 5;
    logic clk_i = 0, rst_i = 1, clear_start_i = 0, dump_start_i = 0;
    logic core_we_i = 0, dump_ready_i = 0;
    logic [AW-1:0] core_waddr_i = '0, core_raddr1_i = '0;
    logic [DW-1:0] core_wdata_i = '0;
    logic busy_o, done_o, rf_we_o, dump_valid_o;
    logic [AW-1:0] rf_waddr_o, rf_raddr1_o, dump_addr_o;
    logic [DW-1:0] rf_wdata_o, rf_rdata1_i, dump_data_o;
    logic [DW-1:0] rf [REG_NUM_C];
    logic [DW-1:0] gold [REG_NUM_C];
    logic [DW-1:0] seen [REG_NUM_C];
    int n_cmp = 0, n_bad = 0;
    int mode = 0;
    int beats = 0, next_clr = 1, done_cnt = 0, busy_cnt = 0;
    logic rand_ready = 0, poke = 0, held = 0;
    logic [AW-1:0] held_addr;
    logic [DW-1:0] held_data;

    rf_debug_port dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_start_i(clear_start_i), .dump_start_i(dump_start_i),
        .busy_o(busy_o), .done_o(done_o), .core_we_i(core_we_i), .core_waddr_i(core_waddr_i),
        .core_wdata_i(core_wdata_i), .core_raddr1_i(core_raddr1_i), .rf_we_o(rf_we_o),
        .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .rf_raddr1_o(rf_raddr1_o),
        .rf_rdata1_i(rf_rdata1_i), .dump_valid_o(dump_valid_o), .dump_ready_i(dump_ready_i),
        .dump_addr_o(dump_addr_o), .dump_data_o(dump_data_o)
    );

    always #5 clk_i = ~clk_i;

    // register file with x0 hardwired to zero and combinational read
    always @(posedge clk_i) if (rf_we_o && rf_waddr_o != '0) rf[rf_waddr_o] <= rf_wdata_o;
    assign rf_rdata1_i = rf_raddr1_o == '0 ? '0 : rf[rf_raddr1_o];

    always @(posedge clk_i) begin
        #1;
        dump_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_i) held = 0;
        else begin
            if (!busy_o) begin
                chk("pass_we", rf_we_o, core_we_i);
                chk("pass_waddr", rf_waddr_o, core_waddr_i);
                chk("pass_wdata", rf_wdata_o, core_wdata_i);
                chk("pass_raddr", rf_raddr1_o, core_raddr1_i);
                if (core_we_i && core_waddr_i != '0) gold[core_waddr_i] = core_wdata_i;
            end else if (mode == 1) begin
                chk("clr_we", rf_we_o, 1);
                chk("clr_addr", rf_waddr_o, next_clr);
                chk("clr_data", rf_wdata_o, 0);
                chk("clr_novalid", dump_valid_o, 0);
                if (next_clr < REG_NUM_C) gold[next_clr] = '0;
                next_clr++;
            end else chk("dump_we", rf_we_o, 0);
            if (held) begin
                chk("hold_valid", dump_valid_o, 1);
                chk("hold_addr", dump_addr_o, held_addr);
                chk("hold_data", dump_data_o, held_data);
            end
            if (dump_valid_o && dump_ready_i) begin
                if (beats < REG_NUM_C) begin
                    chk("beat_addr", dump_addr_o, beats);
                    chk("beat_data", dump_data_o, gold[beats]);
                    seen[beats] = dump_data_o;
                end else chk("extra_beat", beats, REG_NUM_C - 1);
                beats++;
            end
            held = dump_valid_o && !dump_ready_i;
            held_addr = dump_addr_o;
            held_data = dump_data_o;
            if (done_o) begin
                done_cnt++;
                chk("done_idle", busy_o, 0);
            end
            if (busy_o) busy_cnt++;
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic core_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        core_we_i = 1; core_waddr_i = a; core_wdata_i = d;
        step();
        core_we_i = 0;
    endtask

    // lat counts cycles from the start-request cycle to the cycle done_o is seen
    task automatic run_cmd(input logic c, input logic d, output int lat);
        clear_start_i = c; dump_start_i = d;
        done_cnt = 0; busy_cnt = 0; beats = 0; next_clr = 1;
        mode = c ? 1 : 2;
        step();
        clear_start_i = 0; dump_start_i = 0;
        lat = 1;
        while (!done_o && lat < 400) begin
            core_we_i = poke && lat < 11; core_waddr_i = 3; core_wdata_i = 32'hFFFF_FFFF;
            step();
            lat++;
        end
        core_we_i = 0;
        step();
        mode = 0;
    endtask

    initial begin
        int lat;
        for (int k = 0; k < REG_NUM_C; k++) gold[k] = '0;
        repeat (3) step();
        rst_i = 0;
        step();
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_valid", dump_valid_o, 0);
        chk("rst_addr", dump_addr_o, 0);
        chk("rst_data", dump_data_o, 0);
        core_write(5, 32'hDEAD_BEEF);
        core_raddr1_i = 5; #1;
        chk("x5_pre", rf_rdata1_i, 32'hDEAD_BEEF);
        run_cmd(1, 0, lat);
        chk("clr_latency", lat, 32);
        chk("clr_busy_cycles", busy_cnt, 31);
        chk("clr_writes", next_clr - 1, 31);
        chk("clr_done_cnt", done_cnt, 1);
        core_raddr1_i = 5; #1;
        chk("x5_post", rf_rdata1_i, 0);
        for (int k = 1; k < REG_NUM_C; k++) core_write(AW'(k), 32'h1000_0000 + k);
        run_cmd(0, 1, lat);
        chk("dump_latency", lat, 34);
        chk("dump_beats", beats, 32);
        chk("dump_done_cnt", done_cnt, 1);
        chk("dump_x0", seen[0], 0);
        chk("dump_x17", seen[17], 32'h1000_0011);
        chk("dump_x31", seen[31], 32'h1000_001F);
        rand_ready = 1;
        run_cmd(0, 1, lat);
        rand_ready = 0;
        chk("rand_beats", beats, 32);
        chk("rand_done_cnt", done_cnt, 1);
        chk("rand_x31", seen[31], 32'h1000_001F);
        run_cmd(1, 1, lat);
        chk("both_latency", lat, 32);
        chk("both_beats", beats, 0);
        chk("both_done_cnt", done_cnt, 1);
        for (int k = 1; k < REG_NUM_C; k++) core_write(AW'(k), 32'h1000_0000 + k);
        poke = 1;
        run_cmd(0, 1, lat);
        poke = 0;
        chk("poke_beats", beats, 32);
        chk("poke_x3", seen[3], 32'h1000_0003);
        core_raddr1_i = 3; #1;
        chk("poke_rf_x3", rf_rdata1_i, 32'h1000_0003);
        beats = 0; mode = 2;
        dump_start_i = 1;
        step();
        dump_start_i = 0;
        for (int i = 0; i < 100 && beats < 10; i++) step();
        chk("rst_at_beat", beats, 10);
        #2 rst_i = 1;
        #1;
        chk("midrst_valid", dump_valid_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_done", done_o, 0);
        step();
        rst_i = 0; mode = 0;
        step();
        run_cmd(0, 1, lat);
        chk("restart_latency", lat, 34);
        chk("restart_beats", beats, 32);
        chk("restart_x0", seen[0], 0);
        chk("restart_x10", seen[10], 32'h1000_000A);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
